// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//
// N-digit multiplexed seven-segment scan driver for the calculator board.
// Scans one digit per SCAN_TICKS clocks. Digit data is double-buffered:
// `load` fills a staging register, and the staging register is copied to the
// displayed (active) register only at the end of a full scan frame. The
// display never shows half of one value and half of the next.
// Each digit can be enabled, blinked and given a decimal point. Leading zeros
// can be blanked. A 16-level PWM inside each digit slot sets the brightness.
//
// Ports:
//   board_clk      in   system clock
//   Reset          in   asynchronous, active-high reset
//   digits         in   hex nibble per digit, digit 0 = bits [3:0]
//   dp             in   decimal point request per digit (1 = lit)
//   load           in   single-cycle strobe, captures digits/dp into staging
//   digit_en       in   per-digit enable (0 = digit dark)
//   blink          in   per-digit blink enable
//   lz_blank       in   1 = blank leading zeros
//   brightness     in   PWM duty select 0..15 ((brightness+1)/16 on-time)
//   anodes         out  active-low anode drives, bit i = digit i (registered)
//   cathodes       out  active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp} (registered)
//   scan_idx       out  digit currently being scanned
//   frame_pending  out  staged data not yet visible
//
// The file also holds ssd_scan_driver_checker, which carries the output
// invariants as concurrent assertions.
// ---------------------------------------------------------------------------

module ssd_scan_driver_checker #(
  parameter int N_DIGITS = 8
) (
  input logic                        board_clk,
  input logic                        Reset,
  input logic [N_DIGITS-1:0]         anodes,
  input logic [7:0]                  cathodes,
  input logic [$clog2(N_DIGITS)-1:0] scan_idx
);

  localparam int SW = $clog2(N_DIGITS);
  localparam logic [SW-1:0] IDX_LAST = SW'(N_DIGITS - 1);

  // Only one digit may be driven at a time.
  a_one_anode: assert property (@(posedge board_clk) disable iff (Reset)
    $onehot0(~anodes));

  // When every digit is dark, the segments are released as well.
  a_dark_blank: assert property (@(posedge board_clk) disable iff (Reset)
    (&anodes) |-> (cathodes == 8'hFF));

  // The scan position never leaves the digit range.
  a_idx_range: assert property (@(posedge board_clk) disable iff (Reset)
    scan_idx <= IDX_LAST);

endmodule

module ssd_scan_driver #(
  parameter int N_DIGITS   = 8,
  parameter int SCAN_TICKS = 262144,
  parameter int BLINK_DIV  = 26
) (
  input  logic                        board_clk,
  input  logic                        Reset,
  input  logic [4*N_DIGITS-1:0]       digits,
  input  logic [N_DIGITS-1:0]         dp,
  input  logic                        load,
  input  logic [N_DIGITS-1:0]         digit_en,
  input  logic [N_DIGITS-1:0]         blink,
  input  logic                        lz_blank,
  input  logic [3:0]                  brightness,
  output logic [N_DIGITS-1:0]         anodes,
  output logic [7:0]                  cathodes,
  output logic [$clog2(N_DIGITS)-1:0] scan_idx,
  output logic                        frame_pending
);

  localparam int PW = $clog2(SCAN_TICKS);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [PW-1:0]       PS_LAST  = PW'(SCAN_TICKS - 1);
  localparam logic [SW-1:0]       IDX_LAST = SW'(N_DIGITS - 1);
  localparam logic [31:0]         PWM_STEP = 32'(SCAN_TICKS / 16);
  localparam logic [N_DIGITS-1:0] ONE_HOT0 = N_DIGITS'(1);

  // Hex nibble to active-low {Ca..Cg}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h01;
      4'h1:    seg = 7'h4F;
      4'h2:    seg = 7'h12;
      4'h3:    seg = 7'h06;
      4'h4:    seg = 7'h4C;
      4'h5:    seg = 7'h24;
      4'h6:    seg = 7'h20;
      4'h7:    seg = 7'h0F;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h04;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h60;
      4'hC:    seg = 7'h31;
      4'hD:    seg = 7'h42;
      4'hE:    seg = 7'h30;
      4'hF:    seg = 7'h38;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [PW-1:0]         prescaler_r;
  logic [SW-1:0]         scan_idx_r;
  logic [BLINK_DIV-1:0]  blink_cnt_r;
  logic [4*N_DIGITS-1:0] staging_digits_r;
  logic [N_DIGITS-1:0]   staging_dp_r;
  logic [4*N_DIGITS-1:0] active_digits_r;
  logic [N_DIGITS-1:0]   active_dp_r;
  logic                  frame_pending_r;
  logic [N_DIGITS-1:0]   anodes_r;
  logic [7:0]            cathodes_r;

  logic                  tick_s;
  logic                  frame_end_s;
  logic [N_DIGITS-1:0]   lz_mask_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic [6:0]            cur_seg_s;
  logic [31:0]           pwm_limit_s;
  logic                  pwm_on_s;
  logic                  blink_phase_s;
  logic                  visible_s;

  assign tick_s      = (prescaler_r == PS_LAST);
  assign frame_end_s = tick_s && (scan_idx_r == IDX_LAST);

  // Slot prescaler and digit scan position.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      prescaler_r <= '0;
      scan_idx_r  <= '0;
    end else if (tick_s) begin
      prescaler_r <= '0;
      scan_idx_r  <= (scan_idx_r == IDX_LAST) ? '0 : scan_idx_r + SW'(1);
    end else begin
      prescaler_r <= prescaler_r + PW'(1);
      scan_idx_r  <= scan_idx_r;
    end
  end

  // Free-running blink counter; its MSB is the blink phase.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt_r <= '0;
    end else begin
      blink_cnt_r <= blink_cnt_r + BLINK_DIV'(1);
    end
  end

  // Double buffer. At a frame end, active takes the staging value from before
  // this edge, so a load arriving in the same cycle stays pending for a frame.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      staging_digits_r <= '0;
      staging_dp_r     <= '0;
      active_digits_r  <= '0;
      active_dp_r      <= '0;
      frame_pending_r  <= 1'b0;
    end else begin
      if (frame_end_s && frame_pending_r) begin
        active_digits_r <= staging_digits_r;
        active_dp_r     <= staging_dp_r;
      end else begin
        active_digits_r <= active_digits_r;
        active_dp_r     <= active_dp_r;
      end
      if (load) begin
        staging_digits_r <= digits;
        staging_dp_r     <= dp;
        frame_pending_r  <= 1'b1;
      end else begin
        staging_digits_r <= staging_digits_r;
        staging_dp_r     <= staging_dp_r;
        frame_pending_r  <= frame_end_s ? 1'b0 : frame_pending_r;
      end
    end
  end

  // Leading-zero mask. Walk from the top digit down. higher_clear stays set
  // while every digit above is zero or disabled. Digit 0 is never blanked.
  always_comb begin
    logic higher_clear;
    lz_mask_s    = '0;
    higher_clear = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (lz_blank && (i != 0) && higher_clear &&
          (active_digits_r[4*i +: 4] == 4'h0)) begin
        lz_mask_s[i] = 1'b1;
      end else begin
        lz_mask_s[i] = 1'b0;
      end
      if (digit_en[i] && (active_digits_r[4*i +: 4] != 4'h0)) begin
        higher_clear = 1'b0;
      end else begin
        higher_clear = higher_clear;
      end
    end
  end

  // Visibility of the digit in the current slot: enable, blanking, blink and
  // PWM window. The PWM window starts at the beginning of the slot.
  always_comb begin
    cur_nib_s     = active_digits_r[{scan_idx_r, 2'b00} +: 4];
    cur_dp_s      = active_dp_r[scan_idx_r];
    cur_seg_s     = hex_to_seg(cur_nib_s);
    pwm_limit_s   = (32'(brightness) + 32'd1) * PWM_STEP;
    pwm_on_s      = (32'(prescaler_r) < pwm_limit_s);
    blink_phase_s = blink_cnt_r[BLINK_DIV-1];
    visible_s     = digit_en[scan_idx_r] && !lz_mask_s[scan_idx_r] &&
                    !(blink[scan_idx_r] && blink_phase_s) && pwm_on_s;
  end

  // Registered pin drives, one cycle behind the scan state.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      anodes_r   <= '1;
      cathodes_r <= 8'hFF;
    end else if (visible_s) begin
      anodes_r   <= ~(ONE_HOT0 << scan_idx_r);
      cathodes_r <= {cur_seg_s, ~cur_dp_s};
    end else begin
      anodes_r   <= '1;
      cathodes_r <= 8'hFF;
    end
  end

  assign anodes        = anodes_r;
  assign cathodes      = cathodes_r;
  assign scan_idx      = scan_idx_r;
  assign frame_pending = frame_pending_r;

  ssd_scan_driver_checker #(
    .N_DIGITS(N_DIGITS)
  ) u_checker (
    .board_clk(board_clk),
    .Reset    (Reset),
    .anodes   (anodes_r),
    .cathodes (cathodes_r),
    .scan_idx (scan_idx_r)
  );

endmodule

// File: tb/tb_ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_driver
//
// Bench for ssd_scan_driver with 4 digits, 16-clock slots and a 6-bit blink
// counter. A behavioural model tracks the number of cycles since reset plus
// the staged and displayed values. It derives the slot position, PWM window
// and blink phase from that cycle count with plain arithmetic. Directed
// scenarios pin the model with literal expectations. A randomized phase then
// compares the DUT with the model on every cycle.
// ---------------------------------------------------------------------------
module tb_ssd_scan_driver;

  logic        board_clk;
  logic        Reset;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic        lz_blank;
  logic [3:0]  brightness;
  logic [3:0]  anodes;
  logic [7:0]  cathodes;
  logic [1:0]  scan_idx;
  logic        frame_pending;

  ssd_scan_driver #(
    .N_DIGITS  (4),
    .SCAN_TICKS(16),
    .BLINK_DIV (6)
  ) dut (
    .board_clk    (board_clk),
    .Reset        (Reset),
    .digits       (digits),
    .dp           (dp),
    .load         (load),
    .digit_en     (digit_en),
    .blink        (blink),
    .lz_blank     (lz_blank),
    .brightness   (brightness),
    .anodes       (anodes),
    .cathodes     (cathodes),
    .scan_idx     (scan_idx),
    .frame_pending(frame_pending)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  int n_chk;
  int n_pass;

  // model state
  int          mc;
  logic [15:0] m_stage_dig;
  logic [3:0]  m_stage_dp;
  logic [15:0] m_act_dig;
  logic [3:0]  m_act_dp;
  logic        m_pend;
  logic [7:0]  hex_tab [16];

  // expectations for the next sample
  logic [3:0]  exp_an;
  logic [7:0]  exp_ca;
  int          exp_si;
  logic        exp_pend;

  // per-frame observations
  int          low_cnt [4];
  logic [7:0]  seen_ca [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mc          = 0;
    m_stage_dig = 16'h0000;
    m_stage_dp  = 4'h0;
    m_act_dig   = 16'h0000;
    m_act_dp    = 4'h0;
    m_pend      = 1'b0;
  endtask

  // A digit is a leading zero when it is zero and no enabled, non-zero
  // digit exists above it.
  function automatic bit is_lz(input int si);
    if (!lz_blank || si == 0) return 1'b0;
    if (m_act_dig[si*4 +: 4] != 4'h0) return 1'b0;
    for (int j = si + 1; j < 4; j++) begin
      if (digit_en[j] && m_act_dig[j*4 +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Predicts the outputs after the coming clock edge from the current state
  // and inputs, then advances the model by one cycle.
  task automatic predict();
    int         ps;
    int         si;
    int         bph;
    bit         vis;
    bit         fe;
    logic [3:0] nib;
    logic [3:0] one;
    logic [7:0] pat;
    ps  = mc % 16;
    si  = (mc / 16) % 4;
    bph = (mc / 32) % 2;
    nib = m_act_dig[si*4 +: 4];
    vis = digit_en[si] && !(blink[si] && bph == 1) &&
          (ps < int'(brightness) + 1) && !is_lz(si);
    one = 4'b0001;
    pat = hex_tab[nib];
    exp_an = vis ? ~(one << si) : 4'hF;
    exp_ca = vis ? {pat[7:1], ~m_act_dp[si]} : 8'hFF;
    fe = (mc % 64) == 63;
    if (fe && m_pend) begin
      m_act_dig = m_stage_dig;
      m_act_dp  = m_stage_dp;
    end
    if (load) begin
      m_stage_dig = digits;
      m_stage_dp  = dp;
      m_pend      = 1'b1;
    end else if (fe) begin
      m_pend = 1'b0;
    end
    mc++;
    exp_si   = (mc / 16) % 4;
    exp_pend = m_pend;
  endtask

  // One clock with a full comparison against the model.
  task automatic tick1();
    predict();
    @(posedge board_clk);
    @(negedge board_clk);
    chk("anodes", 32'(anodes), 32'(exp_an));
    chk("cathodes", 32'(cathodes), 32'(exp_ca));
    chk("scan_idx", 32'(scan_idx), 32'(exp_si));
    chk("frame_pending", 32'(frame_pending), 32'(exp_pend));
    for (int i = 0; i < 4; i++) begin
      if (anodes[i] == 1'b0) begin
        low_cnt[i]++;
        seen_ca[i] = cathodes;
      end
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) begin
      low_cnt[i] = 0;
      seen_ca[i] = 8'hFF;
    end
  endtask

  // Runs until the next cycle to be clocked is the last one of a frame.
  task automatic run_until_fe();
    while ((mc % 64) != 63) tick1();
  endtask

  // Aligns to a frame start, then observes exactly one frame.
  task automatic frame_capture();
    while ((mc % 64) != 0) tick1();
    clear_obs();
    repeat (64) tick1();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    digits = d;
    dp     = p;
    load   = 1'b1;
    tick1();
    load   = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    hex_tab = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
    Reset      = 1'b1;
    digits     = 16'h0000;
    dp         = 4'h0;
    load       = 1'b0;
    digit_en   = 4'hF;
    blink      = 4'h0;
    lz_blank   = 1'b0;
    brightness = 4'd15;
    clear_obs();
    model_reset();

    // reset state
    repeat (2) @(negedge board_clk);
    chk("rst_anodes", 32'(anodes), 32'h0000000F);
    chk("rst_cathodes", 32'(cathodes), 32'h000000FF);
    chk("rst_scan_idx", 32'(scan_idx), 32'h00000000);
    chk("rst_pending", 32'(frame_pending), 32'h00000000);

    // reset release, blank active register shows '0' on every digit
    Reset = 1'b0;
    tick1();
    chk("first_anodes", 32'(anodes), 32'h0000000E);
    chk("first_cathodes", 32'(cathodes), 32'h00000003);
    frame_capture();
    for (int i = 0; i < 4; i++) begin
      chk("idle_slot_len", 32'(low_cnt[i]), 32'd16);
      chk("idle_pattern", 32'(seen_ca[i]), 32'h00000003);
    end
    chk("idle_pending", 32'(frame_pending), 32'h00000000);

    // load 12AF with dp on digit 0
    do_load(16'h12AF, 4'b0001);
    chk("load_pending", 32'(frame_pending), 32'h00000001);
    run_until_fe();
    chk("pending_before_wrap", 32'(frame_pending), 32'h00000001);
    tick1();
    chk("pending_after_wrap", 32'(frame_pending), 32'h00000000);
    frame_capture();
    chk("d0_F_dp", 32'(seen_ca[0]), 32'h00000070);
    chk("d1_A", 32'(seen_ca[1]), 32'h00000011);
    chk("d2_2", 32'(seen_ca[2]), 32'h00000025);
    chk("d3_1", 32'(seen_ca[3]), 32'h0000009F);

    // load coinciding with frame end: the older staged value shows first
    do_load(16'h4321, 4'b0000);
    run_until_fe();
    do_load(16'h8E06, 4'b1000);
    chk("fe_load_pending", 32'(frame_pending), 32'h00000001);
    frame_capture();
    chk("old_d0", 32'(seen_ca[0]), 32'h0000009F);
    chk("old_d1", 32'(seen_ca[1]), 32'h00000025);
    chk("old_d2", 32'(seen_ca[2]), 32'h0000000D);
    chk("old_d3", 32'(seen_ca[3]), 32'h00000099);
    chk("fe_pending_cleared", 32'(frame_pending), 32'h00000000);
    frame_capture();
    chk("new_d0", 32'(seen_ca[0]), 32'h00000041);
    chk("new_d1", 32'(seen_ca[1]), 32'h00000003);
    chk("new_d2", 32'(seen_ca[2]), 32'h00000061);
    chk("new_d3_dp", 32'(seen_ca[3]), 32'h00000000);

    // leading-zero blanking of 0050
    lz_blank = 1'b1;
    do_load(16'h0050, 4'b0000);
    run_until_fe();
    tick1();
    frame_capture();
    chk("lz_d3_dark", 32'(low_cnt[3]), 32'd0);
    chk("lz_d2_dark", 32'(low_cnt[2]), 32'd0);
    chk("lz_d1_len", 32'(low_cnt[1]), 32'd16);
    chk("lz_d1_5", 32'(seen_ca[1]), 32'h00000049);
    chk("lz_d0_0", 32'(seen_ca[0]), 32'h00000003);
    lz_blank = 1'b0;

    // brightness
    brightness = 4'd3;
    frame_capture();
    for (int i = 0; i < 4; i++) chk("pwm3_len", 32'(low_cnt[i]), 32'd4);
    brightness = 4'd0;
    frame_capture();
    for (int i = 0; i < 4; i++) chk("pwm0_len", 32'(low_cnt[i]), 32'd1);
    brightness = 4'd15;

    // blink: digit 1 slot falls in phase 0, digit 3 slot in phase 1
    blink = 4'b0010;
    frame_capture();
    chk("blink_d1_lit", 32'(low_cnt[1]), 32'd16);
    blink = 4'b1000;
    frame_capture();
    chk("blink_d3_dark", 32'(low_cnt[3]), 32'd0);
    chk("blink_d2_lit", 32'(low_cnt[2]), 32'd16);
    blink = 4'b0000;

    // reset mid-slot with data pending
    do_load(16'h9999, 4'b1111);
    repeat (5) tick1();
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_anodes", 32'(anodes), 32'h0000000F);
    chk("mid_rst_cathodes", 32'(cathodes), 32'h000000FF);
    chk("mid_rst_scan_idx", 32'(scan_idx), 32'h00000000);
    chk("mid_rst_pending", 32'(frame_pending), 32'h00000000);
    @(negedge board_clk);
    Reset = 1'b0;
    model_reset();
    tick1();
    chk("restart_anodes", 32'(anodes), 32'h0000000E);
    frame_capture();
    for (int i = 0; i < 4; i++) chk("restart_pattern", 32'(seen_ca[i]), 32'h00000003);

    // randomized phase
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] d;
      for (int k = 0; k < 4; k++) begin
        d[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      digits = d;
      dp     = 4'($urandom);
      load   = ($urandom_range(0, 19) == 0);
      if ((c % 64) == 0) begin
        digit_en   = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
        blink      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        lz_blank   = 1'($urandom);
        brightness = 4'($urandom);
      end
      tick1();
    end
    load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
